// File: rtl/sid_osc_bank.sv
// sid_osc_bank: bank of SID-style oscillator voices sharing one datapath.
// Each voice-tick strobe (clkEn) snapshots every accumulator MSB, then a
// sequencer updates one voice per clock and pulses oValid when all are done.
//
// Parameters:
//   NUM_VOICES 1..4   number of voices
//   ACC_WIDTH  16..32 phase accumulator width
//   BASE_ADDR         address of voice 0 register 0
//   STRIDE            address distance between voices
// Ports:
//   clk     rising-edge clock
//   iRst    asynchronous active-high reset
//   clkEn   one-cycle voice-tick strobe
//   iWE     register write strobe
//   iAddr   register address (5 bits)
//   iData   write data (8 bits)
//   oVoice  mixed voice outputs, voice i at [12*i+11:12*i]
//   oValid  one-cycle pulse once every voice has been updated for a tick
//   oBusy   high while the sequencer is not idle
//   oOvr    sticky overrun flag (tick arrived while busy)
//   oOsc3   top 8 bits of the last voice (readback)
// Build option:
//   SID_OSC_BANK_READBACK_EN  enables oOsc3 readback; otherwise tied to 0.
module sid_osc_bank #(
    parameter int NUM_VOICES = 3,
    parameter int ACC_WIDTH  = 24,
    parameter int BASE_ADDR  = 0,
    parameter int STRIDE     = 7
) (
    input  logic                      clk,
    input  logic                      iRst,
    input  logic                      clkEn,
    input  logic                      iWE,
    input  logic [4:0]                iAddr,
    input  logic [7:0]                iData,
    output logic [NUM_VOICES*12-1:0]  oVoice,
    output logic                      oValid,
    output logic                      oBusy,
    output logic                      oOvr,
    output logic [7:0]                oOsc3
);

    localparam int NV = NUM_VOICES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       last;
    logic       tick_ok;
    logic       upd;

    // Voice registers; CTRL bit 0 has no function and is not stored.
    logic [NV-1:0][15:0]          freq_q;
    logic [NV-1:0][11:0]          pw_q;
    logic [NV-1:0][7:1]           ctrl_q;
    logic [NV-1:0][4:0]           wsel;

    logic [NV-1:0][ACC_WIDTH-1:0] phase_q;
    logic [NV-1:0][22:0]          lfsr_q;
    logic [NV-1:0][11:0]          voice_q;
    logic [NV-1:0]                snap_q;
    logic [NV-1:0]                snap_prev_q;
    logic                         ovr_q;

    // Shared update datapath operands (selected by idx_q)
    logic [ACC_WIDTH-1:0] ph_cur, ph_d;
    logic [22:0]          lf_cur, lf_d;
    logic [15:0]          f_cur;
    logic [11:0]          pw_cur;
    logic [7:1]           c_cur;
    logic                 src_now, src_old, fell;
    logic [11:0]          p_top, pul, tri_w, noise, mix;

    assign last    = (idx_q == 2'(NV - 1));
    assign tick_ok = clkEn && (state_q == S_IDLE);
    assign upd     = (state_q == S_RUN);

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- sequencer: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (clkEn) begin
                    state_d = S_RUN;
                    idx_d   = 2'd0;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    always_comb begin
        oBusy  = (state_q != S_IDLE);
        oValid = (state_q == S_DONE);
    end

    // ---------------- register write decode ----------------
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (iWE && int'({27'd0, iAddr}) == BASE_ADDR + STRIDE * i + k) begin
                    wsel[i][k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            freq_q <= '0;
            pw_q   <= '0;
            ctrl_q <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (wsel[i][0]) freq_q[i][7:0]  <= iData;
                if (wsel[i][1]) freq_q[i][15:8] <= iData;
                if (wsel[i][2]) pw_q[i][7:0]    <= iData;
                if (wsel[i][3]) pw_q[i][11:8]   <= iData[3:0];
                if (wsel[i][4]) ctrl_q[i]       <= iData[7:1];
            end
        end
    end

    // ---------------- operand select ----------------
    // Sync/ring source is the previous voice (wrapping); it reads only the
    // tick snapshots, so results do not depend on update order.
    always_comb begin
        ph_cur  = '0;
        lf_cur  = '0;
        f_cur   = '0;
        pw_cur  = '0;
        c_cur   = '0;
        src_now = 1'b0;
        src_old = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (idx_q == 2'(i)) begin
                ph_cur  = phase_q[i];
                lf_cur  = lfsr_q[i];
                f_cur   = freq_q[i];
                pw_cur  = pw_q[i];
                c_cur   = ctrl_q[i];
                src_now = snap_q[(i + NV - 1) % NV];
                src_old = snap_prev_q[(i + NV - 1) % NV];
            end
        end
    end

    // ---------------- voice datapath ----------------
    always_comb begin
        fell = src_old & ~src_now;
        if (c_cur[3] || (c_cur[1] && fell)) begin
            ph_d = '0;
        end else begin
            ph_d = ph_cur + ACC_WIDTH'(f_cur);
        end

        if (c_cur[3]) begin
            lf_d = '1;
        end else if (!ph_cur[ACC_WIDTH-5] && ph_d[ACC_WIDTH-5]) begin
            lf_d = {lf_cur[21:0], lf_cur[22] ^ lf_cur[17]};
        end else begin
            lf_d = lf_cur;
        end

        p_top = ph_d[ACC_WIDTH-1 -: 12];
        pul   = (p_top >= pw_cur) ? 12'hFFF : 12'h000;
        tri_w = ph_d[ACC_WIDTH-2 -: 12]
              ^ {12{ph_d[ACC_WIDTH-1] ^ (c_cur[2] & src_now)}};
        noise = {lf_d[20], lf_d[18], lf_d[14], lf_d[11],
                 lf_d[9], lf_d[5], lf_d[2], lf_d[0], 4'b0000};

        mix = 12'hFFF;
        if (c_cur[7]) mix = mix & noise;
        if (c_cur[6]) mix = mix & pul;
        if (c_cur[5]) mix = mix & p_top;
        if (c_cur[4]) mix = mix & tri_w;
        if (c_cur[7:4] == 4'd0) mix = 12'h000;
    end

    // ---------------- voice state ----------------
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            phase_q     <= '0;
            lfsr_q      <= '1;
            voice_q     <= '0;
            snap_q      <= '0;
            snap_prev_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            if (tick_ok) begin
                snap_prev_q <= snap_q;
                for (int i = 0; i < NV; i++) begin
                    snap_q[i] <= phase_q[i][ACC_WIDTH-1];
                end
            end
            for (int i = 0; i < NV; i++) begin
                if (upd && idx_q == 2'(i)) begin
                    phase_q[i] <= ph_d;
                    voice_q[i] <= mix;
                end
                // Test holds the noise generator at all ones continuously.
                if (ctrl_q[i][3]) begin
                    lfsr_q[i] <= '1;
                end else if (upd && idx_q == 2'(i)) begin
                    lfsr_q[i] <= lf_d;
                end
            end
            if (clkEn && state_q != S_IDLE) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign oVoice = voice_q;
    assign oOvr   = ovr_q;

`ifdef SID_OSC_BANK_READBACK_EN
    logic [7:0] osc3_q;

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            osc3_q <= 8'h00;
        end else if (upd && last) begin
            osc3_q <= mix[11:4];
        end
    end

    assign oOsc3 = osc3_q;
`else
    assign oOsc3 = 8'h00;
`endif

endmodule

// File: tb/tb_sid_osc_bank.sv
// tb_sid_osc_bank: directed + randomized self-checking bench for sid_osc_bank
// with an arithmetic reference model of the voice bank.
module tb_sid_osc_bank;

    localparam int NV = 3;
    localparam int AW = 24;

    logic             clk;
    logic             iRst;
    logic             clkEn;
    logic             iWE;
    logic [4:0]       iAddr;
    logic [7:0]       iData;
    logic [NV*12-1:0] oVoice;
    logic             oValid;
    logic             oBusy;
    logic             oOvr;
    logic [7:0]       oOsc3;

    int checks   = 0;
    int failures = 0;

    sid_osc_bank #(
        .NUM_VOICES(NV),
        .ACC_WIDTH (AW),
        .BASE_ADDR (0),
        .STRIDE    (7)
    ) dut (
        .clk   (clk),
        .iRst  (iRst),
        .clkEn (clkEn),
        .iWE   (iWE),
        .iAddr (iAddr),
        .iData (iData),
        .oVoice(oVoice),
        .oValid(oValid),
        .oBusy (oBusy),
        .oOvr  (oOvr),
        .oOsc3 (oOsc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned mph[NV];
    int unsigned mfreq[NV];
    int unsigned mpw[NV];
    int unsigned mctrl[NV];
    int unsigned mlfsr[NV];
    int unsigned mout[NV];
    bit          msnap[NV];
    bit          mprev[NV];
    bit          mfired[NV];
    bit          movr;
    int          npos[8] = '{20, 18, 14, 11, 9, 5, 2, 0};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mreset();
        for (int i = 0; i < NV; i++) begin
            mph[i]   = 0;
            mfreq[i] = 0;
            mpw[i]   = 0;
            mctrl[i] = 0;
            mlfsr[i] = 'h7FFFFF;
            mout[i]  = 0;
            msnap[i] = 0;
            mprev[i] = 0;
            mfired[i] = 0;
        end
        movr = 0;
    endfunction

    function automatic void mwrite(input int a, input int d);
        for (int i = 0; i < NV; i++) begin
            case (a - 7 * i)
                0: mfreq[i] = (mfreq[i] & 'hFF00) | d;
                1: mfreq[i] = (mfreq[i] & 'h00FF) | (d << 8);
                2: mpw[i]   = (mpw[i] & 'hF00) | d;
                3: mpw[i]   = (mpw[i] & 'h0FF) | ((d & 'hF) << 8);
                4: begin
                    mctrl[i] = d & 'hFE;
                    if ((d & 8) != 0) mlfsr[i] = 'h7FFFFF;
                end
                default: ;
            endcase
        end
    endfunction

    // One whole tick: snapshot all MSBs, then apply the rules to each voice.
    function automatic void mtick();
        int unsigned old, p, tw, nz, o, fb;
        int          src;
        bit          any;
        for (int i = 0; i < NV; i++) begin
            mprev[i] = msnap[i];
            msnap[i] = bit'((mph[i] >> (AW - 1)) & 1);
        end
        for (int i = 0; i < NV; i++) begin
            src = (i + NV - 1) % NV;
            old = mph[i];
            mfired[i] = 0;
            if ((mctrl[i] & 8) != 0) begin
                mph[i] = 0;
            end else if ((mctrl[i] & 2) != 0 && mprev[src] && !msnap[src]) begin
                mph[i] = 0;
                mfired[i] = 1;
            end else begin
                mph[i] = (mph[i] + mfreq[i]) & ((1 << AW) - 1);
            end
            if ((mctrl[i] & 8) != 0) begin
                mlfsr[i] = 'h7FFFFF;
            end else if (((old >> (AW - 5)) & 1) == 0 &&
                         ((mph[i] >> (AW - 5)) & 1) == 1) begin
                fb = ((mlfsr[i] >> 22) ^ (mlfsr[i] >> 17)) & 1;
                mlfsr[i] = ((mlfsr[i] << 1) | fb) & 'h7FFFFF;
            end
            p  = mph[i] >> (AW - 12);
            tw = (mph[i] >> (AW - 13)) & 'hFFF;
            if ((((mph[i] >> (AW - 1)) & 1) ^ ((mctrl[i] >> 2) & 1 & msnap[src])) == 1)
                tw = tw ^ 'hFFF;
            nz = 0;
            for (int j = 0; j < 8; j++)
                nz = nz | (((mlfsr[i] >> npos[j]) & 1) << (11 - j));
            o = 'hFFF;
            any = 0;
            if ((mctrl[i] & 'h80) != 0) begin o = o & nz; any = 1; end
            if ((mctrl[i] & 'h40) != 0) begin o = o & ((p >= mpw[i]) ? 'hFFF : 0); any = 1; end
            if ((mctrl[i] & 'h20) != 0) begin o = o & p; any = 1; end
            if ((mctrl[i] & 'h10) != 0) begin o = o & tw; any = 1; end
            mout[i] = any ? o : 0;
        end
    endfunction

    function automatic logic [NV*12-1:0] pack_out();
        logic [NV*12-1:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[12*i +: 12] = 12'(mout[i]);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int a, input int d);
        @(negedge clk);
        iWE   = 1'b1;
        iAddr = 5'(a);
        iData = 8'(d);
        @(negedge clk);
        iWE = 1'b0;
        mwrite(a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        iRst = 1'b1;
        mreset();
        @(negedge clk);
        iRst = 1'b0;
    endtask

    // Issue one tick and check every cycle of the sequence. ovr_k != 0
    // re-raises clkEn k cycles after the accepted one. rel_rst releases
    // reset in the same cycle the tick is raised.
    task automatic do_tick(input int ovr_k, input bit rel_rst);
        logic [NV*12-1:0] bef, aft;
        bef = pack_out();
        mtick();
        aft = pack_out();
        @(negedge clk);
        clkEn = 1'b1;
        if (rel_rst) iRst = 1'b0;
        @(negedge clk);
        clkEn = 1'b0;
        for (int k = 1; k <= NV + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (ovr_k != 0 && k == ovr_k + 1) begin
                clkEn = 1'b0;
                movr = 1'b1;
            end
            for (int i = 0; i < NV; i++)
                chk($sformatf("voice%0d_c%0d", i, k), 64'(oVoice[12*i +: 12]),
                    64'((k >= i + 2) ? aft[12*i +: 12] : bef[12*i +: 12]));
            chk($sformatf("valid_c%0d", k), 64'(oValid), 64'(k == NV + 1));
            chk($sformatf("busy_c%0d", k), 64'(oBusy), 64'(1));
            chk($sformatf("ovr_c%0d", k), 64'(oOvr), 64'(movr));
`ifdef SID_OSC_BANK_READBACK_EN
            chk($sformatf("osc3_c%0d", k), 64'(oOsc3),
                64'((k >= NV + 1) ? aft[NV*12-1 -: 8] : bef[NV*12-1 -: 8]));
`else
            chk($sformatf("osc3_c%0d", k), 64'(oOsc3), 64'(0));
`endif
            if (ovr_k != 0 && k == ovr_k) clkEn = 1'b1;
        end
        @(negedge clk);
        chk("valid_end", 64'(oValid), 64'(0));
        chk("busy_end", 64'(oBusy), 64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, nw, a, d;
        bit fired;
        iRst  = 1'b1;
        clkEn = 1'b0;
        iWE   = 1'b0;
        iAddr = '0;
        iData = '0;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_voice", 64'(oVoice), 64'(0));
        chk("rst_valid", 64'(oValid), 64'(0));
        chk("rst_busy", 64'(oBusy), 64'(0));
        chk("rst_ovr", 64'(oOvr), 64'(0));
        chk("rst_osc3", 64'(oOsc3), 64'(0));
        iRst = 1'b0;

        // Voice 0 sawtooth, FREQ 0x1000, 16 ticks.
        wr(0, 'h00);
        wr(1, 'h10);
        wr(4, 'h20);
        for (int t = 0; t < 16; t++) do_tick(0, 0);
        chk("saw16", 64'(oVoice[11:0]), 64'(12'h010));

        // Voice 1 pulse, PW 0x800, FREQ 0x8000.
        do_reset();
        wr(9, 'h00);
        wr(10, 'h08);
        wr(7, 'h00);
        wr(8, 'h80);
        wr(11, 'h40);
        do_tick(0, 0);
        chk("pulse_first", 64'(oVoice[23:12]), 64'(12'h000));
        for (int t = 0; t < 4; t++) do_tick(0, 0);

        // Voice 2 hard sync to voice 1 MSB fall.
        do_reset();
        wr(7, 'hFF);
        wr(8, 'hFF);
        wr(11, 'h20);
        wr(14, 'h00);
        wr(15, 'h10);
        wr(18, 'h22);
        n = 0;
        fired = 1'b0;
        while (!fired && n < 300) begin
            do_tick(0, 0);
            n++;
            fired = mfired[2];
        end
        chk("sync_zero", 64'(oVoice[35:24]), 64'(12'h000));

        // Same without sync: voice 2 keeps accumulating (P = ticks).
        do_reset();
        wr(7, 'hFF);
        wr(8, 'hFF);
        wr(11, 'h20);
        wr(14, 'h00);
        wr(15, 'h10);
        wr(18, 'h20);
        for (int t = 0; t < n; t++) do_tick(0, 0);
        chk("nosync_acc", 64'(oVoice[35:24]), 64'(12'(n)));

        // Saw AND pulse at P = 0x9AB: 165 ticks of 0xF000.
        do_reset();
        wr(0, 'h00);
        wr(1, 'hF0);
        wr(2, 'h00);
        wr(3, 'h01);
        wr(4, 'h60);
        for (int t = 0; t < 165; t++) do_tick(0, 0);
        chk("sawpul_9ab", 64'(oVoice[11:0]), 64'(12'h9AB));
        wr(1, 'h00);
        wr(2, 'hFF);
        wr(3, 'h0F);
        do_tick(0, 0);
        chk("sawpul_pwfff", 64'(oVoice[11:0]), 64'(12'h000));

        // Random register traffic over the whole address space.
        do_reset();
        for (int r = 0; r < 60; r++) begin
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                a = $urandom_range(0, 31);
                d = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) d = d & 'hF7;
                wr(a, d);
            end
            do_tick(0, 0);
        end

        // Overrun: second clkEn two cycles after the first.
        do_tick(2, 0);
        chk("ovr_set", 64'(oOvr), 64'(1));
        do_tick(0, 0);

        // Reset in the middle of a sequence (index 1).
        @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_busy", 64'(oBusy), 64'(1));
        chk("mid_ovr_held", 64'(oOvr), 64'(1));
        iRst = 1'b1;
        #1;
        chk("mid_voice", 64'(oVoice), 64'(0));
        chk("mid_valid", 64'(oValid), 64'(0));
        chk("mid_busy0", 64'(oBusy), 64'(0));
        chk("mid_ovr", 64'(oOvr), 64'(0));
        chk("mid_osc3", 64'(oOsc3), 64'(0));
        for (int i = 0; i < NV; i++)
            chk($sformatf("mid_lfsr%0d", i), 64'(dut.lfsr_q[i]), 64'(23'h7FFFFF));
        mreset();
        do_tick(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
